life_sequencer: RTL

- Generation controller and board store for the 20x15 Game of Life grid.
- Holds two ping-pong board banks. Sequences one generation row by row into the back bank, then swaps banks.
- Arbitrates bank access between the VGA pixel reader, the cell-edit port and the generation engine.
- Sits between the VGA timing block (VGAx/VGAy, frame tick) and the colour output.

---
 rtl/life_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - ping-pong board store and row-serial Game of Life generation sequencer
module life_sequencer #(
    parameter int MAX_i = 19,
    parameter int MAX_j = 14,
    parameter int WRAP  = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [9:0]  VGAx,
    input  logic [9:0]  VGAy,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        step,
    input  logic        edit_we,
    input  logic [4:0]  edit_x,
    input  logic [3:0]  edit_y,
    input  logic        edit_val,
    input  logic        wipe,
    output logic        edit_ready,
    output logic        busy,
    output logic        gen_done,
    output logic [15:0] gen_count,
    output logic [2:0]  rgb
);

    localparam logic [4:0] X_LAST = 5'(MAX_i);
    localparam logic [3:0] Y_LAST = 4'(MAX_j);

    typedef enum logic [1:0] {IDLE, CALC, SWAP} state_t;

    state_t     state;
    logic       fsel;
    logic       pending;
    logic [3:0] r;

    logic [MAX_i:0] mem [2][MAX_j+1];

    logic trig, edit_act;
    assign trig       = (run & frame_tick) | step;
    assign edit_act   = edit_we | wipe;
    assign edit_ready = ~busy;

    function automatic logic [3:0] count8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
        return s;
    endfunction

    // Bit k of a padded row is column k-1; the pads supply the wrapped or dead edge columns.
    function automatic logic [MAX_i+2:0] pad(input logic [MAX_i:0] row);
        logic w;
        w = (WRAP != 0);
        return {w & row[0], row, w & row[MAX_i]};
    endfunction

    logic [3:0]       r_up, r_dn;
    logic [MAX_i:0]   row_up, row_mid, row_dn, next_row;
    logic [MAX_i+2:0] ext_up, ext_mid, ext_dn;
    logic [7:0]       nb;
    logic [3:0]       ncount;

    always_comb begin
        r_up    = (r == 4'd0) ? Y_LAST : r - 4'd1;
        r_dn    = (r == Y_LAST) ? 4'd0 : r + 4'd1;
        row_mid = mem[fsel][r];
        row_up  = (r == 4'd0 && WRAP == 0) ? '0 : mem[fsel][r_up];
        row_dn  = (r == Y_LAST && WRAP == 0) ? '0 : mem[fsel][r_dn];
        ext_up  = pad(row_up);
        ext_mid = pad(row_mid);
        ext_dn  = pad(row_dn);
        next_row = '0;
        nb       = '0;
        ncount   = '0;
        for (int c = 0; c <= MAX_i; c++) begin
            nb = {ext_up[c], ext_up[c+1], ext_up[c+2], ext_mid[c], ext_mid[c+2],
                  ext_dn[c], ext_dn[c+1], ext_dn[c+2]};
            ncount = count8(nb);
            next_row[c] = (ncount == 4'd3) | (row_mid[c] & (ncount == 4'd2));
        end
    end

    logic [4:0] vx;
    logic [3:0] vy;
    logic       in_grid, pix;
    logic       unused_vga;

    assign vx         = VGAx[9:5];
    assign vy         = VGAy[8:5];
    assign in_grid    = (vx <= X_LAST) && (vy <= Y_LAST);
    assign pix        = in_grid & mem[fsel][in_grid ? vy : 4'd0][in_grid ? vx : 5'd0];
    assign unused_vga = ^{VGAx[4:0], VGAy[9], VGAy[4:0]};

    // The bank select flips on the edge that writes the last row, so the SWAP cycle
    // already presents the new front bank and gen_done coincides with it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            fsel      <= 1'b0;
            pending   <= 1'b0;
            r         <= '0;
            busy      <= 1'b0;
            gen_done  <= 1'b0;
            gen_count <= '0;
            rgb       <= '0;
            for (int b = 0; b < 2; b++)
                for (int y = 0; y <= MAX_j; y++) mem[b][y] <= '0;
        end else begin
            gen_done <= 1'b0;
            rgb      <= {3{pix}};
            case (state)
                IDLE: begin
                    if (wipe) begin
                        for (int b = 0; b < 2; b++)
                            for (int y = 0; y <= MAX_j; y++) mem[b][y] <= '0;
                    end else if (edit_we && edit_x <= X_LAST && edit_y <= Y_LAST) begin
                        mem[fsel][edit_y][edit_x] <= edit_val;
                    end
                    if (edit_act) begin
                        if (trig) pending <= 1'b1;
                    end else if (trig || pending) begin
                        pending <= 1'b0;
                        r       <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (trig) pending <= 1'b1;
                    mem[~fsel][r] <= next_row;
                    if (r == Y_LAST) begin
                        fsel      <= ~fsel;
                        gen_done  <= 1'b1;
                        gen_count <= gen_count + 16'd1;
                        state     <= SWAP;
                    end else begin
                        r <= r + 4'd1;
                    end
                end
                SWAP: begin
                    if (trig) pending <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
